// File: rtl/feature_weight_bank.sv
// Storage for NUM_FEATURES convolution kernels of KERNEL_SIZE^2 two's-complement weights,
// loaded by parallel kernel writes or a serial valid/ready stream, with a registered read port.
module feature_weight_bank #(
    parameter  int KERNEL_SIZE  = 3,
    parameter  int NUM_FEATURES = 10,
    parameter  int WEIGHT_W     = 2,
    localparam int TAPS         = KERNEL_SIZE * KERNEL_SIZE,
    localparam int AW           = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               feature_WrEn,
    input  logic [AW-1:0]                                      address_w,
    input  logic [TAPS-1:0][WEIGHT_W-1:0]                      feature_weights_input,
    input  logic                                               load_start,
    input  logic                                               s_valid,
    output logic                                               s_ready,
    input  logic [WEIGHT_W-1:0]                                s_weight,
    output logic                                               load_busy,
    output logic                                               load_done,
    input  logic                                               rd_en,
    input  logic [AW-1:0]                                      rd_addr,
    output logic [TAPS-1:0][WEIGHT_W-1:0]                      rd_weights,
    output logic                                               rd_valid,
    output logic                                               wr_err,
    output logic [NUM_FEATURES-1:0]                            feature_valid,
    output logic [NUM_FEATURES-1:0][TAPS-1:0][WEIGHT_W-1:0]    feature_weights_output
);

    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [TW-1:0] LAST_TAP    = TW'(TAPS - 1);
    localparam logic [AW-1:0] LAST_KERNEL = AW'(NUM_FEATURES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t                                            state_q, state_d;
    logic [AW-1:0]                                     kernel_q, kernel_d;
    logic [TW-1:0]                                     tap_q, tap_d;
    logic [NUM_FEATURES-1:0][TAPS-1:0][WEIGHT_W-1:0]   mem_q, mem_d;
    logic [NUM_FEATURES-1:0]                           valid_q, valid_d;
    logic [TAPS-1:0][WEIGHT_W-1:0]                     rd_weights_q, rd_weights_d;
    logic                                              rd_valid_q, rd_valid_d;
    logic                                              wr_err_q, wr_err_d;
    logic                                              load_done_q, load_done_d;

    logic wr_ok;
    logic rd_ok;
    logic stream_hs;
    logic last_tap;
    logic last_kernel;

    assign wr_ok       = feature_WrEn && (state_q == IDLE) && (int'(address_w) < NUM_FEATURES);
    assign rd_ok       = rd_en && (int'(rd_addr) < NUM_FEATURES);
    assign stream_hs   = (state_q == LOAD) && s_valid;
    assign last_tap    = (tap_q == LAST_TAP);
    assign last_kernel = (kernel_q == LAST_KERNEL);

    always_comb begin
        state_d     = state_q;
        kernel_d    = kernel_q;
        tap_d       = tap_q;
        load_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d  = LOAD;
                    kernel_d = '0;
                    tap_d    = '0;
                end
            end
            LOAD: begin
                if (stream_hs) begin
                    if (last_tap) begin
                        tap_d = '0;
                        if (last_kernel) begin
                            state_d     = IDLE;
                            kernel_d    = '0;
                            load_done_d = 1'b1;
                        end else begin
                            kernel_d = kernel_q + AW'(1);
                        end
                    end else begin
                        tap_d = tap_q + TW'(1);
                    end
                end
            end
        endcase
    end

    // A load start clears every valid flag last, so it overrides a same-cycle parallel write's flag.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (wr_ok) begin
            mem_d[address_w]   = feature_weights_input;
            valid_d[address_w] = 1'b1;
        end
        if (stream_hs) begin
            mem_d[kernel_q][tap_q] = s_weight;
            if (last_tap) begin
                valid_d[kernel_q] = 1'b1;
            end
        end
        if ((state_q == IDLE) && load_start) begin
            valid_d = '0;
        end
    end

    // Reads sample mem_q, so a same-cycle write to the read kernel returns the old contents.
    always_comb begin
        rd_weights_d = rd_weights_q;
        rd_valid_d   = 1'b0;
        wr_err_d     = (feature_WrEn && !wr_ok) || (rd_en && !rd_ok);
        if (rd_ok) begin
            rd_weights_d = mem_q[rd_addr];
            rd_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            kernel_q     <= '0;
            tap_q        <= '0;
            mem_q        <= '0;
            valid_q      <= '0;
            rd_weights_q <= '0;
            rd_valid_q   <= 1'b0;
            wr_err_q     <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            kernel_q     <= kernel_d;
            tap_q        <= tap_d;
            mem_q        <= mem_d;
            valid_q      <= valid_d;
            rd_weights_q <= rd_weights_d;
            rd_valid_q   <= rd_valid_d;
            wr_err_q     <= wr_err_d;
            load_done_q  <= load_done_d;
        end
    end

    assign s_ready                = (state_q == LOAD);
    assign load_busy              = (state_q == LOAD);
    assign load_done              = load_done_q;
    assign rd_weights             = rd_weights_q;
    assign rd_valid               = rd_valid_q;
    assign wr_err                 = wr_err_q;
    assign feature_valid          = valid_q;
    assign feature_weights_output = mem_q;

endmodule

// File: tb/tb_feature_weight_bank.sv
// Directed bench for feature_weight_bank: a vector table for single-cycle write/read/error
// behaviour plus hand-written stream-load, combined-strobe and reset-mid-load sequences.
module tb_feature_weight_bank;

    localparam int NF   = 10;
    localparam int TAPS = 9;
    localparam int W    = 2;
    localparam int KW   = TAPS * W;
    localparam int MW   = NF * KW;

    logic                          clk;
    logic                          rst;
    logic                          feature_WrEn;
    logic [3:0]                    address_w;
    logic [TAPS-1:0][W-1:0]        feature_weights_input;
    logic                          load_start;
    logic                          s_valid;
    logic                          s_ready;
    logic [W-1:0]                  s_weight;
    logic                          load_busy;
    logic                          load_done;
    logic                          rd_en;
    logic [3:0]                    rd_addr;
    logic [TAPS-1:0][W-1:0]        rd_weights;
    logic                          rd_valid;
    logic                          wr_err;
    logic [NF-1:0]                 feature_valid;
    logic [NF-1:0][TAPS-1:0][W-1:0] feature_weights_output;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        string         name;
        logic          wrEn;
        logic [3:0]    addrW;
        logic [KW-1:0] taps;
        logic          rdEn;
        logic [3:0]    rdAddr;
        logic          expRdValid;
        logic [KW-1:0] expRd;
        logic          expErr;
        logic [NF-1:0] expFv;
    } vec_t;

    vec_t vecs[$];

    feature_weight_bank #(
        .KERNEL_SIZE (3),
        .NUM_FEATURES(NF),
        .WEIGHT_W    (W)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .feature_WrEn          (feature_WrEn),
        .address_w             (address_w),
        .feature_weights_input (feature_weights_input),
        .load_start            (load_start),
        .s_valid               (s_valid),
        .s_ready               (s_ready),
        .s_weight              (s_weight),
        .load_busy             (load_busy),
        .load_done             (load_done),
        .rd_en                 (rd_en),
        .rd_addr               (rd_addr),
        .rd_weights            (rd_weights),
        .rd_valid              (rd_valid),
        .wr_err                (wr_err),
        .feature_valid         (feature_valid),
        .feature_weights_output(feature_weights_output)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] tapBits(input int v);
        logic [31:0] vv;
        vv = v;
        return vv[W-1:0];
    endfunction

    function automatic logic [KW-1:0] fillTaps(input int v);
        logic [KW-1:0] r;
        for (int t = 0; t < TAPS; t++) r[t*W +: W] = tapBits(v);
        return r;
    endfunction

    // Taps {0,1,-2,-1,0,1,-2,-1,0}
    function automatic logic [KW-1:0] patP3();
        logic [KW-1:0] r;
        for (int t = 0; t < TAPS; t++) r[t*W +: W] = tapBits(((t + 2) % 4) - 2);
        return r;
    endfunction

    function automatic logic [KW-1:0] streamKernel(input int k);
        logic [KW-1:0] r;
        for (int t = 0; t < TAPS; t++) r[t*W +: W] = tapBits(((TAPS*k + t) % 4) - 2);
        return r;
    endfunction

    function automatic logic [MW-1:0] streamMem();
        logic [MW-1:0] r;
        for (int k = 0; k < NF; k++) r[k*KW +: KW] = streamKernel(k);
        return r;
    endfunction

    function automatic logic [MW-1:0] tableMem();
        logic [MW-1:0] r;
        r = '0;
        r[3*KW +: KW] = patP3();
        r[5*KW +: KW] = fillTaps(-1);
        r[9*KW +: KW] = fillTaps(-1);
        return r;
    endfunction

    function automatic logic [NF-1:0] doneMask(input int n);
        logic [NF-1:0] r;
        r = '0;
        for (int f = 0; f < NF; f++) if (f < n) r[f] = 1'b1;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic wrEn, input logic [3:0] addrW,
                          input logic [KW-1:0] taps, input logic rdEn, input logic [3:0] rdAddr,
                          input logic expRdValid, input logic [KW-1:0] expRd, input logic expErr,
                          input logic [NF-1:0] expFv);
        vec_t v;
        v.name = name; v.wrEn = wrEn; v.addrW = addrW; v.taps = taps; v.rdEn = rdEn;
        v.rdAddr = rdAddr; v.expRdValid = expRdValid; v.expRd = expRd; v.expErr = expErr;
        v.expFv = expFv;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        feature_WrEn = 1'b0; address_w = '0; feature_weights_input = '0;
        load_start = 1'b0; s_valid = 1'b0; s_weight = '0; rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        feature_WrEn = v.wrEn;
        address_w = v.addrW;
        feature_weights_input = v.taps;
        rd_en = v.rdEn;
        rd_addr = v.rdAddr;
        tick();
        checkOutput({v.name, "_rdValid"}, MW'(rd_valid), MW'(v.expRdValid));
        checkOutput({v.name, "_rdWeights"}, MW'(rd_weights), MW'(v.expRd));
        checkOutput({v.name, "_wrErr"}, MW'(wr_err), MW'(v.expErr));
        checkOutput({v.name, "_fv"}, MW'(feature_valid), MW'(v.expFv));
    endtask

    // One stream handshake for weight i, then checks flags progress and the done pulse.
    task automatic pushWeight(input int i);
        @(negedge clk);
        checkOutput($sformatf("sReady_%0d", i), MW'(s_ready), MW'(1'b1));
        s_valid = 1'b1;
        s_weight = tapBits((i % 4) - 2);
        tick();
        s_valid = 1'b0;
        checkOutput($sformatf("streamFv_%0d", i), MW'(feature_valid), MW'(doneMask((i + 1) / TAPS)));
        checkOutput($sformatf("loadDone_%0d", i), MW'(load_done), MW'(i == NF*TAPS - 1));
    endtask

    task automatic startLoad(input string tag);
        @(negedge clk);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checkOutput({tag, "_busy"}, MW'(load_busy), MW'(1'b1));
        checkOutput({tag, "_fvClear"}, MW'(feature_valid), '0);
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();

        tick();
        tick();
        checkOutput("reset_mem", feature_weights_output, '0);
        checkOutput("reset_fv", MW'(feature_valid), '0);
        checkOutput("reset_sReady", MW'(s_ready), '0);
        checkOutput("reset_rdValid", MW'(rd_valid), '0);
        checkOutput("reset_rdWeights", MW'(rd_weights), '0);
        checkOutput("reset_busy", MW'(load_busy), '0);
        checkOutput("reset_done", MW'(load_done), '0);
        checkOutput("reset_err", MW'(wr_err), '0);
        @(negedge clk);
        rst = 1'b0;

        addVec("wr3",       1, 4'd3,  patP3(),       0, 4'd0,  0, '0,           0, 10'h008);
        addVec("rd3",       0, 4'd0,  '0,            1, 4'd3,  1, patP3(),      0, 10'h008);
        addVec("holdRd",    0, 4'd0,  '0,            0, 4'd0,  0, patP3(),      0, 10'h008);
        addVec("wrBadAddr", 1, 4'd10, fillTaps(1),   0, 4'd0,  0, patP3(),      1, 10'h008);
        addVec("rdBadAddr", 0, 4'd0,  '0,            1, 4'd12, 0, patP3(),      1, 10'h008);
        addVec("wr5",       1, 4'd5,  fillTaps(1),   0, 4'd0,  0, patP3(),      0, 10'h028);
        addVec("hazard5",   1, 4'd5,  fillTaps(-1),  1, 4'd5,  1, fillTaps(1),  0, 10'h028);
        addVec("rd5After",  0, 4'd0,  '0,            1, 4'd5,  1, fillTaps(-1), 0, 10'h028);
        addVec("rd0",       0, 4'd0,  '0,            1, 4'd0,  1, '0,           0, 10'h028);
        addVec("wr9RdBad",  1, 4'd9,  fillTaps(-1),  1, 4'd12, 0, '0,           1, 10'h228);
        addVec("rd9",       0, 4'd0,  '0,            1, 4'd9,  1, fillTaps(-1), 0, 10'h228);
        foreach (vecs[i]) applyStimulus(vecs[i]);
        @(negedge clk);
        clearInputs();
        checkOutput("tableMem", feature_weights_output, tableMem());

        // Stream load with s_valid toggling; a rejected write and ignored restart mid-load.
        startLoad("load1");
        for (int i = 0; i < NF*TAPS; i++) begin
            pushWeight(i);
            @(negedge clk);
            if (i == 45) begin
                feature_WrEn = 1'b1;
                address_w = 4'd2;
                feature_weights_input = fillTaps(1);
                load_start = 1'b1;
                tick();
                clearInputs();
                checkOutput("wrDuringLoad_err", MW'(wr_err), MW'(1'b1));
                checkOutput("wrDuringLoad_busy", MW'(load_busy), MW'(1'b1));
            end else begin
                tick();
                if (i == NF*TAPS - 1) begin
                    checkOutput("load1_donePulseEnd", MW'(load_done), '0);
                    checkOutput("load1_busyEnd", MW'(load_busy), '0);
                end
            end
        end
        checkOutput("load1_mem", feature_weights_output, streamMem());
        checkOutput("load1_fv", MW'(feature_valid), MW'(10'h3FF));

        @(negedge clk);
        rd_en = 1'b1;
        rd_addr = 4'd7;
        tick();
        rd_en = 1'b0;
        checkOutput("rd7_valid", MW'(rd_valid), MW'(1'b1));
        checkOutput("rd7_data", MW'(rd_weights), MW'(streamKernel(7)));

        // Parallel write and load start together: write lands, load begins, flags cleared.
        @(negedge clk);
        feature_WrEn = 1'b1;
        address_w = 4'd0;
        feature_weights_input = fillTaps(1);
        load_start = 1'b1;
        tick();
        clearInputs();
        checkOutput("combo_fv", MW'(feature_valid), '0);
        checkOutput("combo_busy", MW'(load_busy), MW'(1'b1));
        checkOutput("combo_err", MW'(wr_err), '0);
        checkOutput("combo_k0", MW'(feature_weights_output[0]), MW'(fillTaps(1)));

        for (int i = 0; i < 40; i++) pushWeight(i);
        @(negedge clk);
        rst = 1'b1;
        tick();
        checkOutput("midRst_busy", MW'(load_busy), '0);
        checkOutput("midRst_mem", feature_weights_output, '0);
        checkOutput("midRst_fv", MW'(feature_valid), '0);
        checkOutput("midRst_sReady", MW'(s_ready), '0);
        @(negedge clk);
        rst = 1'b0;

        startLoad("load2");
        for (int i = 0; i < NF*TAPS; i++) begin
            if (i == 20) begin
                rd_en = 1'b1;
                rd_addr = 4'd0;
            end
            pushWeight(i);
            if (i == 20) begin
                rd_en = 1'b0;
                checkOutput("rdDuringLoad_valid", MW'(rd_valid), MW'(1'b1));
                checkOutput("rdDuringLoad_data", MW'(rd_weights), MW'(streamKernel(0)));
            end
        end
        checkOutput("load2_busy", MW'(load_busy), '0);
        checkOutput("load2_mem", feature_weights_output, streamMem());
        checkOutput("load2_fv", MW'(feature_valid), MW'(10'h3FF));
        tick();
        checkOutput("load2_doneOnce", MW'(load_done), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
